// File: rtl/tt_um_jimktrains_vslc_eeprom_pkg.sv
// Shared definitions for the VSLC EEPROM reader and writer.
// Opcodes, status bit index and the writer state encoding.
package tt_um_jimktrains_vslc_eeprom_pkg;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;

    localparam int STATUS_WIP = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN,
        ST_GAP,
        ST_WR_CMD,
        ST_WR_DATA,
        ST_END_PAGE,
        ST_POLL,
        ST_NEXT
    } wr_state_t;

endpackage

// File: rtl/tt_um_jimktrains_vslc_eeprom_writer_if.sv
// Byte-stream handshake into the EEPROM writer.
// master drives bytes, slave (the writer) returns ready.
interface tt_um_jimktrains_vslc_eeprom_writer_if;

    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_last;
    logic       wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        input  wr_last,
        output wr_ready
    );

endinterface

// File: rtl/tt_um_jimktrains_vslc_spi_byte.sv
// SCK_DIV-paced SPI mode-0 byte shifter, MSB first.
// byte_done is high on the cycle whose edge ends the last bit.
module tt_um_jimktrains_vslc_spi_byte #(
    parameter int SCK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       rx_mode,
    input  logic       cipo,
    output logic       sck,
    output logic       copi,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       active
);

    localparam logic [15:0] DIV_M1 = 16'(SCK_DIV - 1);

    logic        r_act;
    logic        r_sck;
    logic        r_rxm;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_sh;
    logic [7:0]  r_rx;
    logic        w_tick;

    assign w_tick    = r_act && (r_cnt == '0);
    assign byte_done = w_tick && r_sck && (r_bit == 3'd7);
    assign sck       = r_sck;
    assign copi      = r_act && !r_rxm && r_sh[7];
    assign rx_byte   = r_rx;
    assign active    = r_act;

    // half-period pacing, sample on rise, shift on fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act <= 1'b0;
            r_sck <= 1'b0;
            r_rxm <= 1'b0;
            r_cnt <= '0;
            r_bit <= '0;
            r_sh  <= '0;
            r_rx  <= '0;
        end else if (go) begin
            r_act <= 1'b1;
            r_sck <= 1'b0;
            r_rxm <= rx_mode;
            r_cnt <= DIV_M1;
            r_bit <= '0;
            r_sh  <= tx_byte;
        end else if (r_act) begin
            if (!w_tick) begin
                r_cnt <= r_cnt - 16'd1;
            end else begin
                r_cnt <= DIV_M1;
                if (!r_sck) begin
                    r_sck <= 1'b1;
                    r_rx  <= {r_rx[6:0], cipo};
                end else begin
                    r_sck <= 1'b0;
                    if (r_bit == 3'd7) begin
                        r_act <= 1'b0;
                    end else begin
                        r_bit <= r_bit + 3'd1;
                        r_sh  <= {r_sh[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tt_um_jimktrains_vslc_eeprom_writer.sv
// 25xx EEPROM programmer: WREN, page-bounded WRITE, RDSR poll.
// Owns the SPI pins while busy is high.
module tt_um_jimktrains_vslc_eeprom_writer
    import tt_um_jimktrains_vslc_eeprom_pkg::*;
#(
    parameter int PAGE_SIZE  = 32,
    parameter int SCK_DIV    = 2,
    parameter int POLL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] start_addr,
    tt_um_jimktrains_vslc_eeprom_writer_if.slave wr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        sck,
    output logic        cs_n,
    output logic        copi,
    input  logic        cipo,
    output logic        sd_oe,
    output logic        hold_n
);

    localparam logic [15:0] PMASK  = 16'(PAGE_SIZE - 1);
    localparam logic [15:0] GAP_M1 = 16'(2 * SCK_DIV - 1);
    localparam logic [15:0] LIM_M1 = 16'(POLL_LIMIT - 1);

    wr_state_t   r_state;
    logic [15:0] r_addr;
    logic [15:0] r_gap;
    logic [15:0] r_polls;
    logic [1:0]  r_idx;
    logic        r_cs_n;
    logic        r_sd_oe;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        r_pend;
    logic        r_last;

    logic        w_go;
    logic        w_rxm;
    logic [7:0]  w_tx;
    logic [7:0]  w_rx;
    logic        w_bdone;
    logic        w_act;
    logic        w_ready;
    logic        w_accept;
    logic        w_wip;
    logic        w_unused;

    tt_um_jimktrains_vslc_spi_byte #(
        .SCK_DIV (SCK_DIV)
    ) u_spi (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (w_go),
        .tx_byte   (w_tx),
        .rx_mode   (w_rxm),
        .cipo      (cipo),
        .sck       (sck),
        .copi      (copi),
        .rx_byte   (w_rx),
        .byte_done (w_bdone),
        .active    (w_act)
    );

    assign w_ready  = (r_state == ST_WR_DATA) && !r_cs_n && !r_pend
                      && (!w_act || w_bdone);
    assign w_accept = w_ready && wr.wr_valid;
    assign w_wip    = w_rx[STATUS_WIP];
    assign w_unused = ^w_rx;

    assign wr.wr_ready = w_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign cs_n        = r_cs_n;
    assign sd_oe       = r_sd_oe;
    assign hold_n      = 1'b1;

    // choose when to launch the next byte and what it carries
    always_comb begin
        w_go  = 1'b0;
        w_rxm = 1'b0;
        w_tx  = 8'h00;
        unique case (r_state)
            ST_IDLE: begin
                w_go = start && !r_done;
                w_tx = OP_WREN;
            end
            ST_GAP: begin
                w_go = (r_gap == '0);
                w_tx = OP_WRITE;
            end
            ST_WR_CMD: begin
                w_go = w_bdone && (r_idx != 2'd2);
                w_tx = (r_idx == 2'd0) ? r_addr[15:8] : r_addr[7:0];
            end
            ST_WR_DATA: begin
                w_go = w_accept;
                w_tx = wr.wr_data;
            end
            ST_END_PAGE: begin
                w_go = (r_gap == '0);
                w_tx = OP_RDSR;
            end
            ST_POLL: begin
                w_go  = w_bdone && (r_idx == 2'd0);
                w_rxm = 1'b1;
            end
            ST_NEXT: begin
                w_go = !r_last;
                w_tx = OP_WREN;
            end
            default: ;
        endcase
    end

    // sequencing of frames, chip select and completion flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_gap   <= '0;
            r_polls <= '0;
            r_idx   <= '0;
            r_cs_n  <= 1'b1;
            r_sd_oe <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_pend  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state <= ST_WREN;
                        r_cs_n  <= 1'b0;
                        r_sd_oe <= 1'b1;
                        r_busy  <= 1'b1;
                        r_error <= 1'b0;
                        r_addr  <= start_addr;
                        r_last  <= 1'b0;
                    end
                end
                ST_WREN: begin
                    if (w_bdone) begin
                        r_cs_n  <= 1'b1;
                        r_sd_oe <= 1'b0;
                        r_gap   <= GAP_M1;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) begin
                        r_cs_n  <= 1'b0;
                        r_sd_oe <= 1'b1;
                        r_idx   <= 2'd0;
                        r_state <= ST_WR_CMD;
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                ST_WR_CMD: begin
                    if (w_bdone) begin
                        if (r_idx == 2'd2) begin
                            r_pend  <= 1'b0;
                            r_state <= ST_WR_DATA;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_accept) begin
                        r_addr <= r_addr + 16'd1;
                        if (((r_addr & PMASK) == PMASK) || wr.wr_last)
                            r_pend <= 1'b1;
                        if (wr.wr_last)
                            r_last <= 1'b1;
                    end else if (r_pend && w_bdone) begin
                        r_cs_n  <= 1'b1;
                        r_sd_oe <= 1'b0;
                        r_gap   <= GAP_M1;
                        r_polls <= '0;
                        r_state <= ST_END_PAGE;
                    end
                end
                ST_END_PAGE: begin
                    if (r_gap == '0) begin
                        r_cs_n  <= 1'b0;
                        r_sd_oe <= 1'b1;
                        r_idx   <= 2'd0;
                        r_state <= ST_POLL;
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                ST_POLL: begin
                    if (w_bdone) begin
                        if (r_idx == 2'd0) begin
                            r_idx   <= 2'd1;
                            r_sd_oe <= 1'b0;
                        end else begin
                            r_cs_n  <= 1'b1;
                            r_polls <= r_polls + 16'd1;
                            if (!w_wip) begin
                                r_state <= ST_NEXT;
                            end else if (r_polls == LIM_M1) begin
                                r_error <= 1'b1;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_gap   <= GAP_M1;
                                r_state <= ST_END_PAGE;
                            end
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cs_n  <= 1'b0;
                        r_sd_oe <= 1'b1;
                        r_state <= ST_WREN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_eeprom_writer.sv
// Bench for the EEPROM writer: SPI EEPROM model plus
// frame and completion scoreboards.
module tb_tt_um_jimktrains_vslc_eeprom_writer;
    import tt_um_jimktrains_vslc_eeprom_pkg::*;

    localparam int PS  = 32;
    localparam int DIV = 2;
    localparam int PL  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = 16'h0;
    logic        busy, done, error, sck, cs_n, copi, sd_oe, hold_n;
    logic        cipo = 1'b0;

    tt_um_jimktrains_vslc_eeprom_writer_if wif();

    tt_um_jimktrains_vslc_eeprom_writer #(
        .PAGE_SIZE  (PS),
        .SCK_DIV    (DIV),
        .POLL_LIMIT (PL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .wr         (wif),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .sck        (sck),
        .cs_n       (cs_n),
        .copi       (copi),
        .cipo       (cipo),
        .sd_oe      (sd_oe),
        .hold_n     (hold_n)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    string exp_frames[$];
    bit    exp_err[$];
    logic [7:0] txd[$];

    logic [7:0] mem [0:65535];
    int  wip_reads = 0;
    int  wip_left = 0;
    bit  wel = 0;
    int  sck_rises = 0;

    bit  in_frame = 0;
    int  bitcnt = 0;
    logic [7:0] sh = 8'h0;
    bit  oe_ok = 1;
    logic [7:0] fb[$];
    bit  fo[$];
    logic [7:0] cur_status = 8'h0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string act,
                         input string exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got '%s' want '%s'", nm, act, exp);
        end
    endtask

    task automatic frame_end();
        string s;
        logic [15:0] a;
        s = "";
        for (int i = 0; i < fb.size(); i++) begin
            if (i != 0) s = {s, " "};
            if (fo[i]) s = {s, $sformatf("%02X", fb[i])};
            else       s = {s, "rr"};
        end
        if (bitcnt % 8 != 0) s = {s, " partial"};
        if (exp_frames.size() == 0) chk_s("frame-unexpected", s, "<none>");
        else chk_s("frame", s, exp_frames.pop_front());
        if (fb.size() == 1 && fb[0] == OP_WREN) begin
            wel = 1;
        end else if (fb.size() >= 3 && fb[0] == OP_WRITE && wel) begin
            a = {fb[1], fb[2]};
            for (int i = 3; i < fb.size(); i++) begin
                mem[a] = fb[i];
                a = (a & ~16'(PS - 1)) | ((a + 16'd1) & 16'(PS - 1));
            end
            wel = 0;
            wip_left = wip_reads;
        end else if (fb.size() >= 1 && fb[0] == OP_RDSR && wip_left > 0) begin
            wip_left--;
        end
    endtask

    always @(negedge cs_n) begin
        if (rst_n === 1'b1) begin
            in_frame = 1;
            bitcnt = 0;
            oe_ok = 1;
            fb.delete();
            fo.delete();
            cur_status = 8'($urandom);
            cur_status[0] = (wip_left > 0);
        end
    end

    always @(posedge sck) begin
        sck_rises++;
        if (in_frame && cs_n === 1'b0) begin
            sh = {sh[6:0], copi};
            if (sd_oe !== 1'b1) oe_ok = 0;
            bitcnt++;
            if (bitcnt % 8 == 0) begin
                fb.push_back(sh);
                fo.push_back(oe_ok);
                oe_ok = 1;
            end
        end
    end

    always @(negedge sck) begin
        if (in_frame && fb.size() > 0 && fb[0] == OP_RDSR && fo[0]
            && bitcnt >= 8 && bitcnt < 16)
            cipo = cur_status[3'(15 - bitcnt)];
    end

    always @(posedge cs_n) begin
        if (in_frame) begin
            in_frame = 0;
            cipo = 1'b0;
            if (rst_n === 1'b1) frame_end();
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_err.size() == 0) chk("done-unexpected", 1, 0);
            else chk("done-error", error, exp_err.pop_front());
            chk("done-busy", busy, 0);
            chk("done-csn", cs_n, 1);
        end
    end

    task automatic build_exp(input logic [15:0] addr, input int n);
        int i;
        int polls;
        logic [15:0] a;
        string s;
        i = 0;
        a = addr;
        while (i < n) begin
            exp_frames.push_back("06");
            s = $sformatf("02 %02X %02X", a[15:8], a[7:0]);
            do begin
                s = {s, $sformatf(" %02X", txd[i])};
                i++;
                a = a + 16'd1;
            end while (i < n && (int'(a) % PS) != 0);
            exp_frames.push_back(s);
            polls = wip_reads + 1;
            if (polls > PL) begin
                repeat (PL) exp_frames.push_back("05 rr");
                exp_err.push_back(1);
                return;
            end
            repeat (polls) exp_frames.push_back("05 rr");
        end
        exp_err.push_back(0);
    endtask

    task automatic do_start(input logic [15:0] a);
        int k;
        @(negedge clk);
        start = 1'b1;
        start_addr = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start-busy", busy, 1);
        chk("start-csn", cs_n, 0);
        chk("start-err-clr", error, 0);
        chk("start-no-ready", wif.wr_ready, 0);
        k = 0;
        while (sck !== 1'b1 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("first-sck-rise", k, DIV);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        int b;
        b = 0;
        @(negedge clk);
        wif.wr_data = d;
        wif.wr_last = last;
        wif.wr_valid = 1'b1;
        while (wif.wr_ready !== 1'b1 && b < 5000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 5000) begin
            chk("ready-timeout", 0, 1);
            wif.wr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        wif.wr_valid = 1'b0;
        wif.wr_last = 1'b0;
    endtask

    task automatic stall_check();
        int r0;
        bit csok;
        r0 = sck_rises;
        csok = 1;
        repeat (50) begin
            @(negedge clk);
            if (cs_n !== 1'b0) csok = 0;
        end
        chk("stall-rises", sck_rises - r0, 8);
        chk("stall-cs", csok, 1);
        chk("stall-sck", sck, 0);
        chk("stall-ready", wif.wr_ready, 1);
    endtask

    task automatic wait_done(input bit start_at_done);
        int b;
        b = 0;
        while (done !== 1'b1 && b < 20000) begin
            @(negedge clk);
            b++;
        end
        chk("done-seen", b < 20000, 1);
        #1;
        chk("frames-drained", exp_frames.size(), 0);
        chk("done-queue", exp_err.size(), 0);
        exp_frames.delete();
        exp_err.delete();
        if (start_at_done) begin
            start = 1'b1;
            start_addr = 16'h1234;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (4) @(negedge clk);
            chk("start-at-done-ignored", {busy, cs_n}, 2'b01);
        end
    endtask

    task automatic run_txn(input logic [15:0] addr, input int n,
                           input int wip, input int stall_at,
                           input bit ign, input bit sad);
        logic [15:0] ai;
        wip_reads = wip;
        build_exp(addr, n);
        do_start(addr);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(txd[i], i == n - 1);
            if (ign && i == 0) begin
                @(negedge clk);
                start = 1'b1;
                start_addr = ~addr;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (i == stall_at) stall_check();
        end
        wait_done(sad);
        if (wip < PL) begin
            for (int i = 0; i < n; i++) begin
                ai = addr + 16'(i);
                chk($sformatf("mem[%04X]", ai), mem[ai], txd[i]);
            end
        end
    endtask

    task automatic fill(input int n);
        txd.delete();
        for (int i = 0; i < n; i++) txd.push_back(8'($urandom));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        wif.wr_valid = 1'b0;
        wif.wr_data = 8'h0;
        wif.wr_last = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
        #23;
        chk("reset-outputs",
            {sck, cs_n, copi, sd_oe, hold_n, wif.wr_ready, busy, done, error},
            9'b010010000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        txd.delete();
        txd.push_back(8'hA5);
        run_txn(16'h0004, 1, 3, -1, 0, 0);

        txd.delete();
        txd.push_back(8'h11);
        txd.push_back(8'h22);
        txd.push_back(8'h33);
        txd.push_back(8'h44);
        run_txn(16'h001E, 4, int'($urandom_range(0, 1)), -1, 0, 0);

        fill(4);
        run_txn(16'($urandom), 4, 0, 1, 0, 0);

        fill(1);
        run_txn(16'h0100, 1, 1000, -1, 0, 0);

        fill(2);
        run_txn(16'hFFFF, 2, 1, -1, 1, 1);

        fill(4);
        wip_reads = 0;
        exp_frames.push_back("06");
        do_start(16'h0040);
        send_byte(txd[0], 0);
        send_byte(txd[1], 0);
        b = 0;
        while (sck !== 1'b1 && b < 100) begin
            @(negedge clk);
            b++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async-rst-csn", cs_n, 1);
        chk("async-rst-sck", sck, 0);
        chk("async-rst-busy", busy, 0);
        chk("async-rst-oe", sd_oe, 0);
        chk("rst-frames", exp_frames.size(), 0);
        exp_frames.delete();
        exp_err.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fill(3);
        run_txn(16'h0040, 3, 0, -1, 0, 0);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, 40));
            fill(n);
            run_txn(16'($urandom), n, int'($urandom_range(0, 2)), -1, 0, 0);
        end

        repeat (10) @(negedge clk);
        chk("final-frames", exp_frames.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
